uctl_async_wctl: RTL and testbench
==================================

UCTL_ASYNC_WCTL -- requirements
Module: uctl_async_wctl

Interface
REQ-001 Parameter FIFO_ADDRSIZE, default 2, sets FIFO depth DEPTH = 2^FIFO_ADDRSIZE (legal >= 1).
REQ-002 Parameter SYNC_STAGES, default 2, sets read-pointer synchroniser flop count (legal >= 2; elaboration error otherwise).
REQ-003 Reset wrst_n is asynchronous and active-low; the clock is wclk.
REQ-004 wclk  in  1  write-domain clock.
REQ-005 wrst_n  in  1  asynchronous active-low reset.
REQ-006 winc  in  1  write request.
REQ-007 rptr  in  FIFO_ADDRSIZE+1  Gray-coded read pointer from the read domain.
REQ-008 afull_lvl  in  FIFO_ADDRSIZE+1  almost-full threshold in entries, quasi-static.
REQ-009 ovf_clr  in  1  clear for the sticky overflow flag.
REQ-010 waddr  out  FIFO_ADDRSIZE  RAM write address.
REQ-011 wptr  out  FIFO_ADDRSIZE+1  registered Gray write pointer to the read domain.
REQ-012 wfull  out  1  FIFO full.
REQ-013 wafull  out  1  fill level >= afull_lvl.
REQ-014 wlevel  out  FIFO_ADDRSIZE+1  write-side fill level, 0..DEPTH.
REQ-015 wovf  out  1  sticky overflow (write attempted while full).

Function
REQ-016 rptr SHALL pass through a chain of SYNC_STAGES wclk flops; wq_rptr (last stage) SHALL lag rptr by exactly SYNC_STAGES wclk edges; no logic SHALL sit between stages.
REQ-017 rbin_s SHALL be the combinational Gray-to-binary conversion of wq_rptr.
REQ-018 Write enable wen = winc & ~wfull; a winc while wfull is high SHALL NOT advance any pointer.
REQ-019 Internal binary pointer wbin (FIFO_ADDRSIZE+1 bits) SHALL update to wbin_next = wbin + wen, wrapping modulo 2^(FIFO_ADDRSIZE+1).
REQ-020 wptr SHALL register (wbin_next >> 1) ^ wbin_next, changing at most one bit per cycle.
REQ-021 waddr SHALL equal wbin[FIFO_ADDRSIZE-1:0].
REQ-022 wlevel SHALL register (wbin_next - rbin_s) modulo 2^(FIFO_ADDRSIZE+1).
REQ-023 wfull SHALL register (wbin_next - rbin_s) == DEPTH.
REQ-024 wafull SHALL register (wbin_next - rbin_s) >= afull_lvl; afull_lvl = 0 forces wafull high and afull_lvl > DEPTH forces it low.
REQ-025 Flags are pessimistic:
- wfull/wafull SHALL assert on the edge capturing the filling write;
- they SHALL deassert exactly SYNC_STAGES+1 wclk edges after rptr changes.
REQ-026 wovf SHALL set on any edge with winc & wfull, clear on an edge with ovf_clr alone, and set SHALL take priority over a simultaneous ovf_clr.
REQ-027 A simultaneous write and synchronised read advance SHALL leave wlevel unchanged and SHALL NOT glitch wfull.
REQ-028 The pointer wrap from 2^(FIFO_ADDRSIZE+1)-1 to 0 SHALL be seamless: no flag change due to the wrap itself.

Reset
REQ-029 wrst_n low SHALL immediately clear the synchroniser chain, wbin, wptr, waddr, wlevel, wfull, wafull and wovf to 0, independent of wclk.
REQ-030 Reset asserted mid-operation SHALL discard in-flight state; after release the block SHALL behave as empty with rptr re-synchronised from scratch.
REQ-031 Outputs SHALL remain 0 until the first wclk edge after wrst_n deasserts; wafull SHALL then reflect afull_lvl = 0 if programmed.

Verification (FIFO_ADDRSIZE=2, SYNC_STAGES=2 unless stated)
REQ-032 Reset check: assert wrst_n low between clock edges -> all outputs 0 at once; after release with winc=0 and rptr=0, outputs stay 0.
REQ-033 Fill/overflow: rptr=0, afull_lvl=3, winc high for 5 cycles:
- wptr = 001, 011, 010, 110;
- wafull rises with the 3rd write; wfull rises with the 4th; wlevel=4;
- 5th write is ignored, wptr stays 110, and wovf=1.
REQ-034 Drain latency: from full, rptr -> 001 -> wfull falls and wlevel=3 exactly 3 wclk edges later; waddr=0.
REQ-035 Wrap: rptr tracks wptr delayed; 9 writes -> wbin passes 7->0, wptr 100->000, wfull never asserts.
REQ-036 Overflow clear: ovf_clr and winc-while-full on the same edge -> wovf stays 1; ovf_clr alone on the next edge -> wovf=0.
REQ-037 SYNC_STAGES=3: a single rptr change reaches wq_rptr after 3 edges, and wfull falls on the 4th edge.

Source files
------------

// File: rtl/uctl_async_wctl.sv
// rtl/uctl_async_wctl.sv - write-domain control for an asynchronous FIFO
//
// Write-side pointer/flag logic of a Gray-pointer asynchronous FIFO.
// The read pointer is synchronised into wclk, converted back to binary and
// compared against the next write pointer to produce registered, pessimistic
// full / almost-full / level outputs.
//
// Parameters:
//   FIFO_ADDRSIZE  address width; FIFO depth is 2^FIFO_ADDRSIZE
//   SYNC_STAGES    read-pointer synchroniser depth (>= 2)
//
// Ports:
//   wclk       in   write-domain clock
//   wrst_n     in   asynchronous active-low reset
//   winc       in   write request
//   rptr       in   Gray read pointer from the read domain
//   afull_lvl  in   almost-full threshold in entries (quasi-static)
//   ovf_clr    in   clear for the sticky overflow flag
//   waddr      out  RAM write address
//   wptr       out  registered Gray write pointer to the read domain
//   wfull      out  FIFO full
//   wafull     out  fill level >= afull_lvl
//   wlevel     out  write-side fill level, 0..DEPTH
//   wovf       out  sticky overflow (write attempted while full)

module uctl_async_wctl #(
  parameter int FIFO_ADDRSIZE = 2,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic                     winc,
  input  logic [FIFO_ADDRSIZE:0]   rptr,
  input  logic [FIFO_ADDRSIZE:0]   afull_lvl,
  input  logic                     ovf_clr,
  output logic [FIFO_ADDRSIZE-1:0] waddr,
  output logic [FIFO_ADDRSIZE:0]   wptr,
  output logic                     wfull,
  output logic                     wafull,
  output logic [FIFO_ADDRSIZE:0]   wlevel,
  output logic                     wovf
);

  localparam int             AW    = FIFO_ADDRSIZE + 1;
  localparam logic [AW-1:0]  DEPTH = AW'(1 << FIFO_ADDRSIZE);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("uctl_async_wctl: SYNC_STAGES must be >= 2");
    end
    if (FIFO_ADDRSIZE < 1) begin : g_bad_addrsize
      $error("uctl_async_wctl: FIFO_ADDRSIZE must be >= 1");
    end
  endgenerate

  logic [AW-1:0] r_sync [SYNC_STAGES];
  logic [AW-1:0] r_wbin;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_wlevel;
  logic          r_wfull;
  logic          r_wafull;
  logic          r_wovf;

  logic [AW-1:0] w_wq_rptr;
  logic [AW-1:0] w_rbin_s;
  logic          w_wen;
  logic [AW-1:0] w_wbin_next;
  logic [AW-1:0] w_wgray_next;
  logic [AW-1:0] w_diff;

  // Plain flop chain: nothing between stages so each stage can resolve.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= rptr;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_wq_rptr = r_sync[SYNC_STAGES-1];

  // Gray to binary: bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    w_rbin_s = '0;
    for (int i = 0; i < AW; i++) w_rbin_s[i] = ^(w_wq_rptr >> i);
  end

  assign w_wen        = winc & ~r_wfull;
  assign w_wbin_next  = r_wbin + {{FIFO_ADDRSIZE{1'b0}}, w_wen};
  assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;
  // Modulo-2^AW difference keeps the pointer wrap invisible to the flags.
  assign w_diff       = w_wbin_next - w_rbin_s;

  // Flags are computed from the post-write pointer so they assert on the
  // edge that captures the filling write, and only fall once the stale
  // synchronised read pointer catches up.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wbin   <= '0;
      r_wptr   <= '0;
      r_wlevel <= '0;
      r_wfull  <= 1'b0;
      r_wafull <= 1'b0;
      r_wovf   <= 1'b0;
    end else begin
      r_wbin   <= w_wbin_next;
      r_wptr   <= w_wgray_next;
      r_wlevel <= w_diff;
      r_wfull  <= (w_diff == DEPTH);
      r_wafull <= (w_diff >= afull_lvl);
      // A rejected write beats a simultaneous clear so no overflow is lost.
      if (winc & r_wfull)
        r_wovf <= 1'b1;
      else if (ovf_clr)
        r_wovf <= 1'b0;
    end
  end

  assign waddr  = r_wbin[FIFO_ADDRSIZE-1:0];
  assign wptr   = r_wptr;
  assign wlevel = r_wlevel;
  assign wfull  = r_wfull;
  assign wafull = r_wafull;
  assign wovf   = r_wovf;

endmodule

// File: tb/tb_uctl_async_wctl.sv
// tb/tb_uctl_async_wctl.sv - self-checking bench for uctl_async_wctl
module tb_uctl_async_wctl;

  localparam int M     = 8;
  localparam int DEPTH = 4;
  localparam int S     = 2;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       winc = 1'b0;
  logic [2:0] rptr = '0;
  logic [2:0] afull_lvl = 3'd3;
  logic       ovf_clr = 1'b0;
  logic [1:0] waddr;
  logic [2:0] wptr;
  logic       wfull, wafull, wovf;
  logic [2:0] wlevel;

  logic       b_winc = 1'b0;
  logic [2:0] b_rptr = '0;
  logic [2:0] b_afull_lvl = 3'd4;
  logic       b_ovf_clr = 1'b0;
  logic [1:0] b_waddr;
  logic [2:0] b_wptr;
  logic       b_wfull, b_wafull, b_wovf;
  logic [2:0] b_wlevel;

  int n_chk = 0;
  int n_err = 0;

  int cnt, rcnt, m_lvl;
  bit m_full, m_afull, m_ovf;
  int q[$];

  always #5 wclk = ~wclk;

  uctl_async_wctl #(.FIFO_ADDRSIZE(2), .SYNC_STAGES(2)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .rptr(rptr),
    .afull_lvl(afull_lvl), .ovf_clr(ovf_clr), .waddr(waddr), .wptr(wptr),
    .wfull(wfull), .wafull(wafull), .wlevel(wlevel), .wovf(wovf)
  );

  uctl_async_wctl #(.FIFO_ADDRSIZE(2), .SYNC_STAGES(3)) dut3 (
    .wclk(wclk), .wrst_n(wrst_n), .winc(b_winc), .rptr(b_rptr),
    .afull_lvl(b_afull_lvl), .ovf_clr(b_ovf_clr), .waddr(b_waddr), .wptr(b_wptr),
    .wfull(b_wfull), .wafull(b_wafull), .wlevel(b_wlevel), .wovf(b_wovf)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // Decode by search: the binary count whose Gray code matches.
  function automatic int ungray(input int g);
    for (int i = 0; i < M; i++) if (gray(i) == g) return i;
    return 0;
  endfunction

  task automatic model_reset();
    cnt = 0; rcnt = 0; m_lvl = 0;
    m_full = 0; m_afull = 0; m_ovf = 0;
    q.delete();
    for (int i = 0; i < S; i++) q.push_back(0);
  endtask

  task automatic check_all();
    chk("waddr",  int'(waddr),  cnt % DEPTH);
    chk("wptr",   int'(wptr),   gray(cnt));
    chk("wlevel", int'(wlevel), m_lvl);
    chk("wfull",  int'(wfull),  int'(m_full));
    chk("wafull", int'(wafull), int'(m_afull));
    chk("wovf",   int'(wovf),   int'(m_ovf));
  endtask

  // One wclk cycle: the model sees the read pointer as it stood S samples ago.
  task automatic tick();
    int used, wen;
    @(posedge wclk);
    used = ungray(q.pop_front());
    q.push_back(int'(rptr));
    wen = (winc && !m_full) ? 1 : 0;
    if (winc && m_full) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    cnt     = (cnt + wen) % M;
    m_lvl   = (cnt - used + M) % M;
    m_full  = (m_lvl == DEPTH);
    m_afull = (m_lvl >= int'(afull_lvl));
    @(negedge wclk);
    check_all();
  endtask

  task automatic do_reset();
    #2;
    wrst_n = 1'b0;
    #1;
    chk("rst_waddr",  int'(waddr),  0);
    chk("rst_wptr",   int'(wptr),   0);
    chk("rst_wlevel", int'(wlevel), 0);
    chk("rst_wfull",  int'(wfull),  0);
    chk("rst_wafull", int'(wafull), 0);
    chk("rst_wovf",   int'(wovf),   0);
    chk("rst3_wfull", int'(b_wfull), 0);
    winc = 0; ovf_clr = 0; rptr = '0;
    model_reset();
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  logic [2:0] fill_wptr [4];

  initial begin
    fill_wptr[0] = 3'b001; fill_wptr[1] = 3'b011;
    fill_wptr[2] = 3'b010; fill_wptr[3] = 3'b110;
    model_reset();
    repeat (2) @(negedge wclk);

    // Reset asserted mid-cycle, then idle after release.
    do_reset();
    repeat (3) tick();

    // Almost-full threshold of zero shows up only after the first edge.
    do_reset();
    afull_lvl = 3'd0;
    #1;
    chk("rel_wafull_pre", int'(wafull), 0);
    tick();
    chk("rel_wafull_post", int'(wafull), 1);

    // Fill to full and overflow.
    afull_lvl = 3'd3;
    winc = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("fill_wptr", int'(wptr), int'(fill_wptr[i < 4 ? i : 3]));
      chk("fill_wafull", int'(wafull), (i >= 2) ? 1 : 0);
      chk("fill_wfull", int'(wfull), (i >= 3) ? 1 : 0);
    end
    chk("fill_wlevel", int'(wlevel), 4);
    chk("fill_wovf", int'(wovf), 1);

    // Overflow clear: rejected write wins, then clear alone.
    ovf_clr = 1;
    tick();
    chk("ovf_hold", int'(wovf), 1);
    winc = 0;
    tick();
    chk("ovf_clr", int'(wovf), 0);
    ovf_clr = 0;

    // Drain latency: one read seen three edges later.
    rcnt = 1; rptr = 3'(gray(rcnt));
    tick(); chk("drain_e1", int'(wfull), 1);
    tick(); chk("drain_e2", int'(wfull), 1);
    tick(); chk("drain_e3", int'(wfull), 0);
    chk("drain_lvl", int'(wlevel), 3);
    chk("drain_waddr", int'(waddr), 0);

    // Wrap: continuous write with the reader chasing.
    for (int i = 0; i < 12; i++) begin
      winc = 1;
      if (rcnt != cnt) rcnt = (rcnt + 1) % M;
      rptr = 3'(gray(rcnt));
      tick();
    end
    winc = 0;

    // Randomized traffic with occasional threshold changes and one reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      winc    = ($urandom_range(0, 99) < 60);
      ovf_clr = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 99) < 5) afull_lvl = 3'($urandom_range(0, 7));
      if (rcnt != cnt && ($urandom_range(0, 99) < 45)) rcnt = (rcnt + 1) % M;
      rptr = 3'(gray(rcnt));
      tick();
    end
    winc = 0; ovf_clr = 0;

    // Three-stage synchroniser: full falls on the fourth edge.
    do_reset();
    b_winc = 1;
    repeat (4) begin @(posedge wclk); @(negedge wclk); end
    chk("s3_full", int'(b_wfull), 1);
    b_winc = 0;
    b_rptr = 3'b001;
    for (int e = 1; e <= 4; e++) begin
      @(posedge wclk); @(negedge wclk);
      chk("s3_drain", int'(b_wfull), (e < 4) ? 1 : 0);
    end
    chk("s3_level", int'(b_wlevel), 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
